// File: rtl/stream_map_addk.sv
// Elastic valid/ready pipeline that adds the constant K to every element.
// Supports wrap or saturating arithmetic, a sticky overflow flag and an output counter.
module stream_map_addk #(
   parameter int          WIDTH  = 8,
   parameter int          K      = 1,
   parameter int unsigned STAGES = 1,
   parameter bit          SAT    = 1'b0,
   parameter bit          SIGNED = 1'b0,
   parameter int unsigned CNTW   = 16
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [WIDTH-1:0] sIn,
   input  logic             sIn_valid,
   output logic             sIn_ready,
   output logic [WIDTH-1:0] sOut,
   output logic             sOut_valid,
   input  logic             sOut_ready,
   output logic             ovf,
   output logic [CNTW-1:0]  count
);

   localparam int unsigned XW = WIDTH + 1;
   localparam logic [WIDTH:0] K_EXT = XW'(K);

   logic [WIDTH:0]   a_ext;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] res;
   logic             res_ovf;

   logic [STAGES-1:0] v_q, v_d;
   logic [STAGES-1:0] tag_q, tag_d;
   logic [STAGES-1:0] r;
   logic [WIDTH-1:0]  d_q [STAGES];
   logic [WIDTH-1:0]  d_d [STAGES];
   logic              ovf_q, ovf_d;
   logic [CNTW-1:0]   count_q, count_d;
   logic              out_xfer;

   // The (WIDTH+1)-bit sum is exact, so its top bit(s) classify the overflow direction.
   always_comb begin
      a_ext   = {SIGNED & sIn[WIDTH-1], sIn};
      sum     = a_ext + K_EXT;
      res_ovf = SIGNED ? (sum[WIDTH] ^ sum[WIDTH-1]) : sum[WIDTH];
      res     = sum[WIDTH-1:0];
      if (SAT && res_ovf) begin
         if (SIGNED) begin
            res = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
         end else begin
            res = (K > 0) ? '1 : '0;
         end
      end
   end

   always_comb begin : ready_chain
      logic chain;
      r     = '0;
      chain = sOut_ready;
      for (int unsigned j = 0; j < STAGES; j++) begin
         chain              = ~v_q[STAGES-1-j] | chain;
         r[STAGES-1-j]      = chain;
      end
   end

   always_comb begin
      v_d   = v_q;
      tag_d = tag_q;
      d_d   = d_q;
      if (r[0]) begin
         v_d[0]   = sIn_valid;
         d_d[0]   = res;
         tag_d[0] = res_ovf;
      end
      for (int unsigned j = 1; j < STAGES; j++) begin
         if (r[j]) begin
            v_d[j]   = v_q[j-1];
            d_d[j]   = d_q[j-1];
            tag_d[j] = tag_q[j-1];
         end
      end
      out_xfer = v_q[STAGES-1] & sOut_ready;
      ovf_d    = ovf_q | (out_xfer & tag_q[STAGES-1]);
      count_d  = count_q + CNTW'(out_xfer);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         v_q     <= '0;
         tag_q   <= '0;
         ovf_q   <= 1'b0;
         count_q <= '0;
         for (int unsigned j = 0; j < STAGES; j++) begin
            d_q[j] <= '0;
         end
      end else begin
         v_q     <= v_d;
         tag_q   <= tag_d;
         ovf_q   <= ovf_d;
         count_q <= count_d;
         d_q     <= d_d;
      end
   end

   assign sIn_ready  = r[0];
   assign sOut       = d_q[STAGES-1];
   assign sOut_valid = v_q[STAGES-1];
   assign ovf        = ovf_q;
   assign count      = count_q;

endmodule

// File: doc/stream_map_addk.md
Name: stream_map_addk

Overview:
- Parametrised successor to the single-stage add-1 stream map.
- Adds a compile-time constant K to every element of one valid/ready stream through a STAGES-deep elastic pipeline.
- Offers wrap or saturating arithmetic (unsigned or signed), a sticky overflow flag and an output element counter.
- Sits between stream producers and consumers in generated dataflow designs; sustains one element per cycle under full backpressure support.

Parameters:
- WIDTH, 8, data width in bits (>=2).
- K, 1, addend; signed integer, must fit in WIDTH bits as signed.
- STAGES, 1, pipeline register stages (1..8); equals latency in cycles.
- SAT, 0, 0 = wrap modulo 2^WIDTH; 1 = clamp to range.
- SIGNED, 0, 0 = unsigned data; 1 = two's-complement data.
- CNTW, 16, width of the element counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- nrst  in  1  asynchronous active-low reset
- sIn  in  WIDTH  input element
- sIn_valid  in  1  input element present
- sIn_ready  out  1  block accepts the input this cycle
- sOut  out  WIDTH  result element
- sOut_valid  out  1  result present
- sOut_ready  in  1  consumer accepts the result this cycle
- ovf  out  1  sticky; set when any accepted element overflowed or was clamped
- count  out  CNTW  number of elements delivered on sOut since reset

Behaviour:
- Reset: nrst low asynchronously clears all stage valid bits, sOut_valid=0, ovf=0, count=0. Stage data registers are cleared to 0. Reset mid-stream discards all in-flight elements, with no partial output.
- Pipeline: stage i holds valid v[i] and data d[i]. Stage 0 takes input, stage STAGES-1 drives sOut/sOut_valid.
- Ready chain (combinational): r[STAGES-1] = !v[STAGES-1] | sOut_ready; r[i] = !v[i] | r[i+1]; sIn_ready = r[0].
- Stage i loads from its predecessor when r[i] is high. It takes v[i] <= v[i-1] (or sIn_valid at stage 0) and data accordingly.
- Transfer rules: an input transfer occurs when sIn_valid & sIn_ready; an output transfer when sOut_valid & sOut_ready.
- Latency is exactly STAGES cycles from input transfer to sOut_valid when there is no backpressure. Throughput is one element per cycle.
- A held output (sOut_valid & !sOut_ready) keeps sOut stable until transfer. The pipeline fills behind it. sIn_ready drops only when all STAGES slots are valid and sOut_ready is low.
- sIn_ready must not depend combinationally on sIn_valid.
- Arithmetic: computed at stage 0 on a WIDTH+1 bit extended sum (zero- or sign-extended per SIGNED).
  - Unsigned overflow: carry out (K>0) or borrow (K<0).
  - Signed overflow: sign of the sum differs from the sign of the operand when the operand and K have the same sign.
  - SAT=0: result is the low WIDTH bits.
  - SAT=1: overflow clamps to max (2^WIDTH-1, or 2^(WIDTH-1)-1) or min (0, or -2^(WIDTH-1)) according to direction.
  - Overflow is evaluated per element. A per-stage ovf tag travels with the data.
- ovf: set on the cycle a tagged element leaves on sOut (output transfer). It stays set until reset.
- count: increments by 1 on each output transfer and wraps modulo 2^CNTW. There is no saturation.
- Simultaneous input and output transfer with a full pipeline: both occur, and occupancy is unchanged.
- K=0 is legal: the block becomes a pure elastic delay, and ovf never sets.

Test Plan:
- Default params: sIn counts 0,1,2,... with sIn_valid=1 and sOut_ready=1 -> sOut 1,2,3,... one per cycle after 1 cycle latency; count tracks outputs; ovf=0.
- WIDTH=8, SAT=0, sIn=255 -> sOut=0, ovf=1 after that transfer. SAT=1, sIn=255 -> sOut=255, ovf=1. sIn=254 -> sOut=255, ovf=0.
- SIGNED=1, K=-3, SAT=1, sIn=-127 (0x81) -> sOut=-128 (0x80), ovf=1. sIn=5 -> sOut=2.
- STAGES=3, sOut_ready=0 for 10 cycles with sIn_valid=1 -> exactly 3 input transfers, then sIn_ready=0. sOut stays stable. After release, the elements exit in order with no loss or duplication.
- Random sIn_valid/sOut_ready (50%) over 1000 elements, STAGES=4 -> output sequence equals input+K in order; count=1000 mod 2^CNTW.
- Assert nrst low while the pipeline is full -> sOut_valid=0, count=0, ovf=0 immediately (asynchronously). Elements in flight never appear, and streaming resumes cleanly after release.
